// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the multi-cycle RV32I datapath: one ALU, one memory port.
// Optional macro ILLEGAL_OP_TRAP_EN adds an ERROR trap state and the illegal_op output.
module multicycle_control_fsm #(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       mem_timeout,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic       illegal_op,
`endif
  output logic [3:0] state_dbg
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [7:0] LP_MAX = 8'(MAX_WAIT);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
`ifdef ILLEGAL_OP_TRAP_EN
    S_JAL      = 4'd11,
    S_ERROR    = 4'd12
`else
    S_JAL      = 4'd11
`endif
  } state_t;

  state_t     r_state, w_next;
  logic [1:0] w_aluop;
  logic [7:0] r_wait_cnt;
  logic       r_timeout;
  logic       w_stall;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RESET;
    else     r_state <= w_next;
  end

  // Only the three memory-facing states can stall on mem_ready.
  assign w_stall = ((r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                    (r_state == S_MEMWRITE)) && !mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else if (w_stall) begin
      if (r_wait_cnt < LP_MAX)          r_wait_cnt <= r_wait_cnt + 8'd1;
      if (r_wait_cnt >= LP_MAX - 8'd1)  r_timeout  <= 1'b1;
    end else begin
      r_wait_cnt <= 8'd0;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_aluop    = 2'b00;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    ALUControl = 3'b000;

    if (r_state != S_RESET) begin
      case (Op)
        OP_SW:   ImmSrc = 2'b01;
        OP_BEQ:  ImmSrc = 2'b10;
        OP_JAL:  ImmSrc = 2'b11;
        default: ImmSrc = 2'b00;
      endcase
    end

    case (r_state)
      S_RESET: w_next = S_FETCH;
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (Op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      w_next = S_ERROR;
`else
          default:      w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (Op == OP_LW)      w_next = S_MEMREAD;
        else if (Op == OP_SW) w_next = S_MEMWRITE;
        else                  w_next = S_FETCH;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        w_aluop = 2'b10;
        w_next  = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_aluop = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        w_aluop = 2'b01;
        PCWrite = Zero;
        w_next  = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        w_next  = S_ALUWB;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_ERROR: w_next = S_ERROR;
`endif
      default: w_next = S_FETCH;
    endcase

    // Immediate-form ops never subtract: Op[5] separates addi from sub.
    case (w_aluop)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (Op[5] && funct7[5]) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  assign mem_timeout = r_timeout;
  assign state_dbg   = r_state;
`ifdef ILLEGAL_OP_TRAP_EN
  assign illegal_op  = (r_state == S_ERROR);
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench: per-cycle expected state/controls queued with the stimulus, popped each cycle.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] Op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, mem_timeout;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state_dbg;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       illegal_op;
`endif

  multicycle_control_fsm #(.MAX_WAIT(2)) dut (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .mem_timeout(mem_timeout),
`ifdef ILLEGAL_OP_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic xto   = 1'b0;

  function automatic logic [15:0] C(input logic pcw, adr, mw, irw, rw,
                                    input logic [1:0] rs, sa, sb, im,
                                    input logic [2:0] alu);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, im, alu};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic rdy, input logic [3:0] st, input logic [15:0] ctl);
    exp_t e;
    e.rdy = rdy; e.st = st; e.ctl = ctl; e.to = xto;
    q.push_back(e);
  endtask

  task automatic pf(input logic rdy, input logic [1:0] im);
    push(rdy, 4'd1, C(rdy, 1'b0, 1'b0, rdy, 1'b0, 2'b10, 2'b00, 2'b10, im, 3'b000));
  endtask

  task automatic pd(input logic [1:0] im);
    push(1'b1, 4'd2, C(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, im, 3'b000));
  endtask

  // Pops one entry per cycle; the queue is finite so this always ends.
  task automatic drain();
    exp_t e;
    logic [15:0] ctl;
    while (q.size() > 0) begin
      e = q.pop_front();
      mem_ready = e.rdy;
      #1;
      ctl = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
      chk($sformatf("state@%0d", cyc), 32'(state_dbg), 32'(e.st));
      chk($sformatf("ctl@%0d", cyc), 32'(ctl), 32'(e.ctl));
      chk($sformatf("timeout@%0d", cyc), 32'(mem_timeout), 32'(e.to));
`ifdef ILLEGAL_OP_TRAP_EN
      chk($sformatf("illegal@%0d", cyc), 32'(illegal_op), 32'(e.st == 4'd12));
`endif
      cyc++;
      @(posedge clk); #2;
    end
  endtask

  localparam logic [15:0] ZERO = 16'h0000;

  initial begin
    rst = 1'b1; Op = 7'd0; funct3 = 3'd0; funct7 = 7'd0; Zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #2;
    push(1'b1, 4'd0, ZERO); push(1'b1, 4'd0, ZERO);
    drain();
    rst = 1'b0;
    push(1'b1, 4'd0, ZERO);

    // lw, zero-wait
    Op = 7'b0000011; funct3 = 3'b010;
    drain();
    pf(1'b1, 2'b00); pd(2'b00);
    push(1'b1, 4'd3, C(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000));
    push(1'b1, 4'd4, C(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    push(1'b1, 4'd5, C(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000));
    drain();

    // R-type sub, with one fetch stall (below timeout threshold)
    Op = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0100000;
    pf(1'b0, 2'b00); pf(1'b1, 2'b00); pd(2'b00);
    push(1'b1, 4'd7, C(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001));
    push(1'b1, 4'd9, C(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    drain();

    // R-type add
    funct7 = 7'b0000000;
    pf(1'b1, 2'b00); pd(2'b00);
    push(1'b1, 4'd7, C(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000));
    push(1'b1, 4'd9, C(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    drain();

    // R-type or
    funct3 = 3'b110;
    pf(1'b1, 2'b00); pd(2'b00);
    push(1'b1, 4'd7, C(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b011));
    push(1'b1, 4'd9, C(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    drain();

    // addi with funct7[5] set still adds; then slti, andi
    Op = 7'b0010011; funct3 = 3'b000; funct7 = 7'b0100000;
    pf(1'b1, 2'b00); pd(2'b00);
    push(1'b1, 4'd8, C(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000));
    push(1'b1, 4'd9, C(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    drain();
    funct3 = 3'b010;
    pf(1'b1, 2'b00); pd(2'b00);
    push(1'b1, 4'd8, C(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b101));
    push(1'b1, 4'd9, C(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    drain();
    funct3 = 3'b111;
    pf(1'b1, 2'b00); pd(2'b00);
    push(1'b1, 4'd8, C(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b010));
    push(1'b1, 4'd9, C(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    drain();

    // beq taken, then not taken
    Op = 7'b1100011; funct3 = 3'b000; funct7 = 7'd0; Zero = 1'b1;
    pf(1'b1, 2'b10); pd(2'b10);
    push(1'b1, 4'd10, C(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001));
    drain();
    Zero = 1'b0;
    pf(1'b1, 2'b10); pd(2'b10);
    push(1'b1, 4'd10, C(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001));
    drain();

    // jal
    Op = 7'b1101111;
    pf(1'b1, 2'b11); pd(2'b11);
    push(1'b1, 4'd11, C(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000));
    push(1'b1, 4'd9, C(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000));
    drain();

    // sw with 3 stall cycles: flag rises after the 2nd stall edge and sticks
    Op = 7'b0100011; funct3 = 3'b010;
    pf(1'b1, 2'b01); pd(2'b01);
    push(1'b1, 4'd3, C(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000));
    push(1'b0, 4'd6, C(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000));
    push(1'b0, 4'd6, C(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000));
    xto = 1'b1;
    push(1'b0, 4'd6, C(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000));
    push(1'b1, 4'd6, C(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000));
    drain();

    // unrecognised opcode
    Op = 7'b1111111; funct3 = 3'b000;
    pf(1'b1, 2'b00); pd(2'b00);
`ifdef ILLEGAL_OP_TRAP_EN
    push(1'b1, 4'd12, ZERO); push(1'b1, 4'd12, ZERO); push(1'b1, 4'd12, ZERO);
`else
    pf(1'b1, 2'b00);
`endif
    drain();

    // reset clears the sticky flag and returns to FETCH
    rst = 1'b1; Op = 7'd0;
    @(posedge clk); #2;
    xto = 1'b0;
    push(1'b1, 4'd0, ZERO);
    drain();
    rst = 1'b0;
    push(1'b1, 4'd0, ZERO); pf(1'b1, 2'b00);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle sequencer for the RV32I core. It replaces the single-cycle main/ALU decoders with a Moore FSM that time-shares one ALU and one unified memory port across Fetch, Decode, Execute, Memory and Writeback steps. It drives the datapath mux selects and write strobes, and stalls on a memory-ready handshake. It covers lw, sw, R-type, I-type ALU, beq and jal.

Parameters:
MAX_WAIT, 15, memory wait cycles tolerated before mem_timeout is flagged (1..255).

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
Op  in  7  instruction opcode from IR
funct3  in  3  instruction funct3
funct7  in  7  instruction funct7
Zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  IR/OldPC load enable
RegWrite  out  1  register file write enable
ResultSrc  out  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  out  2  ALU A mux: 00 PC, 01 OldPC, 10 rs1
ALUSrcB  out  2  ALU B mux: 00 rs2, 01 ImmExt, 10 constant 4
ImmSrc  out  2  immediate type: 00 I, 01 S, 10 B, 11 J
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
mem_timeout  out  1  sticky memory-timeout flag
state_dbg  out  4  current state encoding

Behaviour:
- Clocking and reset:
  - Single clk domain. State is updated on the rising edge.
  - rst high at an edge: state set to RESET (0), wait counter cleared, mem_timeout cleared. This applies from any state, including mid-access.
- Output timing: all outputs are combinational from state, plus Zero, mem_ready and funct fields. There are no output registers.
- RESET state outputs: every output is 0; state_dbg = 0. Next state is FETCH unconditionally.
- State encoding: RESET 0, FETCH 1, DECODE 2, MEMADR 3, MEMREAD 4, MEMWB 5, MEMWRITE 6, EXECR 7, EXECI 8, ALUWB 9, BEQ 10, JAL 11, ERROR 12.
- Default value for any output not listed per state below: 0.
- ImmSrc is decoded from Op in every state: lw/I-type 00, sw 01, beq 10, jal 11, other 00.
- ALUOp (internal):
  - 00 gives add.
  - 01 gives sub.
  - 10 decodes funct3:
    - 000: sub if Op[5] and funct7[5], else add.
    - 010: slt.
    - 110: or.
    - 111: and.
    - other: add.
- Per-state outputs and transitions:
  - FETCH: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10.
    - IRWrite = PCWrite = mem_ready.
    - Advance to DECODE when mem_ready; otherwise stay.
  - DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00 (branch target into ALUOut).
    - Next state by Op: lw/sw to MEMADR, R-type to EXECR, I-type to EXECI, beq to BEQ, jal to JAL, other to FETCH.
  - MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00.
    - Next: MEMREAD if Op = lw, MEMWRITE if Op = sw.
  - MEMREAD: AdrSrc 1, ResultSrc 00. Wait for mem_ready, then go to MEMWB.
  - MEMWB: ResultSrc 01, RegWrite 1. Next: FETCH.
  - MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite 1. MemWrite is held until mem_ready, then go to FETCH.
  - EXECR: ALUSrcA 10, ALUSrcB 00, ALUOp 10. Next: ALUWB.
  - EXECI: ALUSrcA 10, ALUSrcB 01, ALUOp 10. Next: ALUWB.
  - ALUWB: ResultSrc 00, RegWrite 1. Next: FETCH.
  - BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, PCWrite = Zero. Next: FETCH.
  - JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCWrite 1. Next: ALUWB (writes PC+4 to rd).
- Instruction latencies: lw 5 cycles, sw 4, R/I 4, beq 3, jal 4 (zero-wait memory). Each memory stall cycle adds 1.
- Wait counter:
  - Counts consecutive cycles in FETCH, MEMREAD or MEMWRITE with mem_ready = 0.
  - Cleared on mem_ready or on leaving the state.
  - Saturates at MAX_WAIT and sets mem_timeout; mem_timeout stays set until rst.
  - The FSM keeps waiting after timeout; there is no abort.

Optional Feature:
ILLEGAL_OP_TRAP_EN
- Defined:
  - An unrecognised Op in DECODE goes to ERROR.
  - ERROR drives all strobes 0 and stays until rst.
  - An extra output illegal_op (1 bit) is 1 only in ERROR.
- Undefined: an unrecognised Op returns to FETCH (treated as nop). There is no ERROR state and no illegal_op port.

Test Plan:
- rst high 2 cycles then low, mem_ready = 1 -> state_dbg 0, then 1 on the first edge after release; all strobes 0 during RESET.
- lw (Op 0000011), mem_ready = 1 -> state sequence 1,2,3,4,5,1; RegWrite = 1 with ResultSrc = 01 only in state 5.
- R-type sub (Op 0110011, funct3 000, funct7 0100000) -> states 1,2,7,9; ALUControl 001 in EXECR; same with funct7 0 gives 000.
- beq with Zero = 1 then Zero = 0 -> PCWrite 1 in BEQ for the first and 0 for the second; both return to FETCH after 3 cycles.
- sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite held 4 cycles, then FETCH. With MAX_WAIT = 2 -> mem_timeout rises and stays set until rst.
- Op 1111111 in DECODE -> FETCH when the macro is undefined; ERROR (12) with illegal_op = 1 until rst when defined.
